pht_gshare_predictor: RTL and testbench

- Gshare direction predictor: table of 2-bit saturating counters indexed by PC XOR global history.
- Front end: issues a registered taken/not-taken prediction per lookup and speculatively shifts it into the GHR.
- Back end: accepts resolved-branch updates from execute, performs read-modify-write of the counter, and restores the GHR on mispredict.
- Sits between fetch (lookup) and branch resolution (update).

---
 rtl/pht_gshare_predictor_if.sv | 33 +++
 rtl/pht_gshare_predictor.sv | 91 +++++++++
 tb/tb_pht_gshare_predictor.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pht_gshare_predictor_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pht_gshare_predictor_if : lookup/prediction and branch-update bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface pht_gshare_predictor_if #(
  parameter int INDEX_W = 6,
  parameter int PC_W    = 32
);
  logic               lk_valid;
  logic [PC_W-1:0]    lk_pc;
  logic               pred_valid;
  logic               pred_taken;
  logic [INDEX_W-1:0] pred_ghr;
  logic               upd_valid;
  logic [PC_W-1:0]    upd_pc;
  logic [INDEX_W-1:0] upd_ghr;
  logic               upd_taken;
  logic               upd_mispredict;

  modport master (
    output lk_valid, lk_pc,
    output upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    input  pred_valid, pred_taken, pred_ghr
  );

  modport slave (
    input  lk_valid, lk_pc,
    input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    output pred_valid, pred_taken, pred_ghr
  );
endinterface
`default_nettype wire

// File: rtl/pht_gshare_predictor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pht_gshare_predictor : gshare table of 2-bit counters, speculative GHR
// Rev 1.0
// ----------------------------------------------------------------------------
module pht_gshare_predictor #(
  parameter int INDEX_W = 6,
  parameter int PC_W    = 32
) (
  input  wire logic               clk,
  input  wire logic               resetn,
  pht_gshare_predictor_if.slave   bus
);
  localparam int DEPTH = 2 ** INDEX_W;

  logic [1:0]         r_pht [DEPTH];
  logic [INDEX_W-1:0] r_ghr;
  logic               r_pred_valid;
  logic               r_pred_taken;
  logic [INDEX_W-1:0] r_pred_ghr;

  logic [INDEX_W-1:0] w_lk_idx;
  logic [INDEX_W-1:0] w_upd_idx;
  logic [1:0]         w_upd_old;
  logic [1:0]         w_upd_new;
  logic [1:0]         w_lk_ctr;
  logic               w_lk_taken;
  logic [INDEX_W-1:0] w_ghr_next;
  logic               w_unused;

  assign w_lk_idx  = bus.lk_pc[INDEX_W+1:2] ^ r_ghr;
  assign w_upd_idx = bus.upd_pc[INDEX_W+1:2] ^ bus.upd_ghr;
  assign w_upd_old = r_pht[w_upd_idx];

  always_comb begin
    w_upd_new = w_upd_old;
    if (bus.upd_taken) begin
      if (w_upd_old != 2'b11) w_upd_new = w_upd_old + 2'b01;
    end else begin
      if (w_upd_old != 2'b00) w_upd_new = w_upd_old - 2'b01;
    end
  end

  // A lookup hitting the entry being updated this cycle sees the new value.
  always_comb begin
    w_lk_ctr = r_pht[w_lk_idx];
    if (bus.upd_valid && (w_upd_idx == w_lk_idx)) w_lk_ctr = w_upd_new;
  end
  assign w_lk_taken = w_lk_ctr[1];

  // Mispredict restore wins over the speculative shift of a same-cycle lookup.
  always_comb begin
    w_ghr_next = r_ghr;
    if (bus.lk_valid)
      w_ghr_next = {r_ghr[INDEX_W-2:0], w_lk_taken};
    if (bus.upd_valid && bus.upd_mispredict)
      w_ghr_next = {bus.upd_ghr[INDEX_W-2:0], bus.upd_taken};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_pht[i] <= 2'b11;
    end else if (bus.upd_valid) begin
      r_pht[w_upd_idx] <= w_upd_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ghr        <= '0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_ghr   <= '0;
    end else begin
      r_ghr        <= w_ghr_next;
      r_pred_valid <= bus.lk_valid;
      if (bus.lk_valid) begin
        r_pred_taken <= w_lk_taken;
        r_pred_ghr   <= r_ghr;
      end
    end
  end

  assign bus.pred_valid = r_pred_valid;
  assign bus.pred_taken = r_pred_taken;
  assign bus.pred_ghr   = r_pred_ghr;

  assign w_unused = ^{bus.lk_pc[PC_W-1:INDEX_W+2], bus.lk_pc[1:0],
                      bus.upd_pc[PC_W-1:INDEX_W+2], bus.upd_pc[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_pht_gshare_predictor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pht_gshare_predictor : directed and random checks against a counter model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pht_gshare_predictor;
  localparam int INDEX_W = 6;
  localparam int PC_W    = 32;
  localparam int DEPTH   = 64;

  logic clk;
  logic resetn;

  pht_gshare_predictor_if #(.INDEX_W(INDEX_W), .PC_W(PC_W)) bus ();

  pht_gshare_predictor #(.INDEX_W(INDEX_W), .PC_W(PC_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: counters as integers 0..3, history as an integer.
  int m_ctr [DEPTH];
  int m_ghr;
  int m_known = 0;
  int e_pv, e_pt, e_pg;

  function automatic int sat(input int c, input int taken);
    if (taken != 0) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  always @(posedge clk) begin
    int li, ui, c, nc, ng;
    if (resetn === 1'b0) begin
      for (int i = 0; i < DEPTH; i++) m_ctr[i] = 3;
      m_ghr = 0; e_pv = 0; e_pt = 0; e_pg = 0;
      m_known = 1;
    end else if (m_known != 0) begin
      ng = m_ghr;
      ui = ((bus.upd_pc >> 2) % DEPTH) ^ bus.upd_ghr;
      nc = sat(m_ctr[ui], bus.upd_taken);
      if (bus.lk_valid) begin
        li = ((bus.lk_pc >> 2) % DEPTH) ^ m_ghr;
        c  = (bus.upd_valid && li == ui) ? nc : m_ctr[li];
        e_pt = c / 2;
        e_pg = m_ghr;
        ng = (m_ghr * 2 + e_pt) % DEPTH;
      end
      e_pv = bus.lk_valid;
      if (bus.upd_valid) begin
        m_ctr[ui] = nc;
        if (bus.upd_mispredict) ng = (bus.upd_ghr * 2 + bus.upd_taken) % DEPTH;
      end
      m_ghr = ng;
    end
  end

  always @(negedge clk) begin
    if (m_known != 0) begin
      check("model_pred_valid", int'(bus.pred_valid), e_pv);
      check("model_pred_taken", int'(bus.pred_taken), e_pt);
      check("model_pred_ghr",   int'(bus.pred_ghr),   e_pg);
    end
  end

  // Set inputs at a falling edge, return at the next falling edge.
  task automatic tick(input logic rn, input logic lk, input int lpc,
                      input logic uv, input int upc, input int ughr,
                      input logic ut, input logic um);
    resetn             = rn;
    bus.lk_valid       = lk;
    bus.lk_pc          = lpc;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_ghr        = ughr[INDEX_W-1:0];
    bus.upd_taken      = ut;
    bus.upd_mispredict = um;
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input int pc);
    tick(1, 1, pc, 0, 0, 0, 0, 0);
  endtask

  task automatic update(input int pc, input int g, input logic t, input logic m);
    tick(1, 0, 0, 1, pc, g, t, m);
  endtask

  int exp_taken_seq [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    resetn = 1'b0;
    bus.lk_valid = 0; bus.lk_pc = 0; bus.upd_valid = 0; bus.upd_pc = 0;
    bus.upd_ghr = 0; bus.upd_taken = 0; bus.upd_mispredict = 0;
    @(negedge clk);

    do_reset();
    check("reset_pred_valid", int'(bus.pred_valid), 0);
    check("reset_pred_taken", int'(bus.pred_taken), 0);
    check("reset_pred_ghr",   int'(bus.pred_ghr),   0);

    lookup(32'h40);
    check("first_lookup_valid", int'(bus.pred_valid), 1);
    check("first_lookup_taken", int'(bus.pred_taken), 1);
    check("first_lookup_ghr",   int'(bus.pred_ghr),   0);
    lookup(32'h0);
    check("ghr_after_shift", int'(bus.pred_ghr), 1);
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    check("idle_valid_low", int'(bus.pred_valid), 0);
    check("idle_ghr_hold",  int'(bus.pred_ghr),   1);

    do_reset();
    update(32'h40, 0, 0, 0);
    update(32'h40, 0, 0, 0);
    lookup(32'h40);
    check("two_nt_taken", int'(bus.pred_taken), 0);
    check("two_nt_ghr",   int'(bus.pred_ghr),   0);

    // Mispredict flag used only to pin GHR to the outcome bit before each lookup.
    do_reset();
    for (int i = 0; i < 3; i++) update(32'h14, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      int t;
      t = (i < 4) ? 1 : 0;
      update(32'h14, 0, t[0], 1);
      lookup((5 ^ t) << 2);
      check("sat_walk_taken", int'(bus.pred_taken), exp_taken_seq[i]);
    end

    do_reset();
    update(32'h0, 1, 1, 1);
    tick(1, 1, 32'h0, 1, 32'h0, 6'b101010, 1, 1);
    check("restore_pred_ghr", int'(bus.pred_ghr), 6'b000011);
    lookup(32'h0);
    check("restore_ghr_next", int'(bus.pred_ghr), 6'b010101);

    do_reset();
    update(32'h40, 0, 0, 0);
    tick(1, 1, 32'h40, 1, 32'h40, 0, 0, 0);
    check("bypass_taken", int'(bus.pred_taken), 0);
    lookup(32'h40);
    check("single_write_taken", int'(bus.pred_taken), 0);
    update(32'h40, 0, 1, 0);
    lookup(32'h40);
    check("single_write_stored01", int'(bus.pred_taken), 1);

    for (int i = 0; i < 3; i++) update(32'h40, 0, 0, 0);
    lookup(32'h0);
    tick(0, 1, 32'h40, 1, 32'h40, 0, 0, 1);
    check("midreset_valid", int'(bus.pred_valid), 0);
    check("midreset_taken", int'(bus.pred_taken), 0);
    check("midreset_ghr",   int'(bus.pred_ghr),   0);
    lookup(32'h40);
    check("midreset_ctr_restored", int'(bus.pred_taken), 1);
    check("midreset_ghr_zero",     int'(bus.pred_ghr),   0);

    for (int n = 0; n < 3000; n++) begin
      logic rn, lk, uv, ut, um;
      int lpc, upc, ug;
      rn  = ($urandom_range(0, 99) != 0);
      lk  = ($urandom_range(0, 3) != 0);
      uv  = ($urandom_range(0, 2) != 0);
      ut  = $urandom_range(0, 1) == 1;
      um  = ($urandom_range(0, 4) == 0);
      lpc = $urandom;
      upc = ($urandom_range(0, 3) == 0) ? lpc : $urandom;
      ug  = ($urandom_range(0, 3) == 0) ? m_ghr : $urandom_range(0, 63);
      tick(rn, lk, lpc, uv, upc, ug, ut, um);
    end

    tick(1, 0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
